// File: rtl/ntt_reorder_pkg.sv
// ---------------------------------------------------------------------------
// ntt_reorder_pkg : shared types, sizes and bit-reverse helper for reorder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ntt_reorder_pkg;

  localparam int LOGQ_DEF = 32;
  localparam int LOGN_DEF = 10;
  localparam int N_HALF   = 2 ** (LOGN_DEF - 1);
  localparam int ADDR_W   = LOGN_DEF - 1;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  function automatic int unsigned n_half(input int unsigned logn);
    return 32'd1 << (logn - 32'd1);
  endfunction

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = {<<{v}};
    return r >> (32 - w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_reorder_bank.sv
// ---------------------------------------------------------------------------
// ntt_reorder_bank : simple dual-port RAM, one write + one registered read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_reorder_bank
  import ntt_reorder_pkg::*;
#(
  parameter int DW    = LOGQ_DEF,
  parameter int DEPTH = N_HALF,
  parameter int AW    = ADDR_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ntt_mdc_reorder_out.sv
// ---------------------------------------------------------------------------
// ntt_mdc_reorder_out : ping-pong buffer turning bit-reversed MDC output into
//                       natural half-split two-lane order
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ntt_mdc_reorder_out
  import ntt_reorder_pkg::*;
#(
  parameter int LOGQ = LOGQ_DEF,
  parameter int LOGN = LOGN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] in_0,
  input  logic [LOGQ-1:0] in_1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_0,
  output logic [LOGQ-1:0] out_1,
  output logic            out_last,
  output logic            overflow
);

  localparam int             C_NH   = int'(n_half(LOGN));
  localparam int             C_AW   = LOGN - 1;
  localparam logic [C_AW-1:0] C_LAST = C_AW'(C_NH - 1);

  logic [C_AW-1:0] wr_k_q, wr_k_d;
  logic            wr_sel_q, wr_sel_d;
  logic [1:0]      full_q, full_d;
  logic            ovf_q, ovf_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [C_AW-1:0] rd_j_q, rd_j_d;
  logic            rd_sel_q, rd_sel_d;
  logic            pend_q, pend_sel_q, pend_last_q;

  logic [LOGQ-1:0] sk0_q [2];
  logic [LOGQ-1:0] sk1_q [2];
  logic [1:0]      sklast_q;
  logic            sk_wp_q, sk_rp_q;
  logic [1:0]      sk_cnt_q;

  logic [LOGQ-1:0] w_bank_lo [2];
  logic [LOGQ-1:0] w_bank_hi [2];
  logic [C_AW-1:0] w_waddr;
  logic            w_wr_en, w_pop, w_space, w_rd_avail, w_issue, w_rd_done;
  logic [LOGQ-1:0] w_rd_lo, w_rd_hi;

  assign w_wr_en = in_valid && !full_q[wr_sel_q];
  assign w_waddr = C_AW'(bitrev(32'(wr_k_q) << 1, LOGN));

  // The first read goes out in the same cycle the buffer is seen full, so
  // the first beat appears two edges after the last write.
  assign w_rd_avail = (rd_state_q == RD_STREAM) || full_q[rd_sel_q];
  assign w_pop      = (sk_cnt_q != 2'd0) && out_ready;
  assign w_space    = ({1'b0, sk_cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, w_pop});
  assign w_issue    = w_rd_avail && w_space;
  assign w_rd_done  = w_issue && (rd_j_q == C_LAST);

  always_comb begin
    wr_k_d     = wr_k_q;
    wr_sel_d   = wr_sel_q;
    full_d     = full_q;
    ovf_d      = ovf_q;
    rd_state_d = rd_state_q;
    rd_j_d     = rd_j_q;
    rd_sel_d   = rd_sel_q;

    if (w_wr_en) begin
      if (wr_k_q == C_LAST) begin
        wr_k_d           = '0;
        wr_sel_d         = ~wr_sel_q;
        full_d[wr_sel_q] = 1'b1;
      end else begin
        wr_k_d = wr_k_q + 1'b1;
      end
    end
    if (in_valid && full_q[wr_sel_q]) ovf_d = 1'b1;

    case (rd_state_q)
      RD_IDLE:   if (full_q[rd_sel_q]) rd_state_d = RD_STREAM;
      default:   rd_state_d = rd_state_q;
    endcase

    if (w_issue) begin
      rd_j_d = rd_j_q + 1'b1;
      if (w_rd_done) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rd_state_d       = full_q[~rd_sel_q] ? RD_STREAM : RD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_k_q      <= '0;
      wr_sel_q    <= 1'b0;
      full_q      <= '0;
      ovf_q       <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rd_j_q      <= '0;
      rd_sel_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      wr_k_q      <= wr_k_d;
      wr_sel_q    <= wr_sel_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      rd_state_q  <= rd_state_d;
      rd_j_q      <= rd_j_d;
      rd_sel_q    <= rd_sel_d;
      pend_q      <= w_issue;
      pend_sel_q  <= rd_sel_q;
      pend_last_q <= w_rd_done;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    logic w_we, w_re;
    assign w_we = w_wr_en && (wr_sel_q == 1'(b));
    assign w_re = w_issue && (rd_sel_q == 1'(b));

    ntt_reorder_bank #(.DW(LOGQ), .DEPTH(C_NH), .AW(C_AW)) u_lo (
      .clk     (clk),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (in_0),
      .re_i    (w_re),
      .raddr_i (rd_j_q),
      .rdata_o (w_bank_lo[b])
    );

    ntt_reorder_bank #(.DW(LOGQ), .DEPTH(C_NH), .AW(C_AW)) u_hi (
      .clk     (clk),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (in_1),
      .re_i    (w_re),
      .raddr_i (rd_j_q),
      .rdata_o (w_bank_hi[b])
    );
  end

  assign w_rd_lo = pend_sel_q ? w_bank_lo[1] : w_bank_lo[0];
  assign w_rd_hi = pend_sel_q ? w_bank_hi[1] : w_bank_hi[0];

  // Skid entries catch reads already in flight when out_ready drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 2; e++) begin
        sk0_q[e] <= '0;
        sk1_q[e] <= '0;
      end
      sklast_q <= '0;
      sk_wp_q  <= 1'b0;
      sk_rp_q  <= 1'b0;
      sk_cnt_q <= 2'd0;
    end else begin
      if (pend_q) begin
        sk0_q[sk_wp_q]    <= w_rd_lo;
        sk1_q[sk_wp_q]    <= w_rd_hi;
        sklast_q[sk_wp_q] <= pend_last_q;
        sk_wp_q           <= ~sk_wp_q;
      end
      if (w_pop) sk_rp_q <= ~sk_rp_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, pend_q} - {1'b0, w_pop};
    end
  end

  assign out_valid = (sk_cnt_q != 2'd0);
  assign out_0     = sk0_q[sk_rp_q];
  assign out_1     = sk1_q[sk_rp_q];
  assign out_last  = sklast_q[sk_rp_q];
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_mdc_reorder_out.sv
// ---------------------------------------------------------------------------
// tb_ntt_mdc_reorder_out : randomized self-checking bench with queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ntt_mdc_reorder_out;

  localparam int LOGQ = 16;
  localparam int LOGN = 4;
  localparam int NH   = 8;
  localparam int N    = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [LOGQ-1:0] in_0 = '0;
  logic [LOGQ-1:0] in_1 = '0;
  logic            out_valid, out_last, overflow;
  logic [LOGQ-1:0] out_0, out_1;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        l;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  bit          exp_drop = 0, exp_ovf = 0, rand_ready = 0, abort_in = 0;
  beat_t       exp_q[$];
  beat_t       e;
  logic [15:0] part [N];
  int          mk = 0, i0 = 0, cyc = 0;
  int          last_in_cyc = -1, first_v_cyc = -1;
  int          n_out = 0, first_pop = -1, last_pop = -1, n_last = 0;
  logic [15:0] got0[$];
  logic [15:0] got1[$];
  bit          stall_prev = 0;
  logic [15:0] prev0, prev1;
  logic        prevl;

  ntt_mdc_reorder_out #(.LOGQ(LOGQ), .LOGN(LOGN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_0      (in_0),
    .in_1      (in_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_0     (out_0),
    .out_1     (out_1),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic int brev(input int v, input int w);
    int r;
    r = 0;
    for (int i = 0; i < w; i++)
      if (((v >> i) & 1) != 0) r = r | (1 << (w - 1 - i));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: place each accepted coefficient at its natural index; a complete
  // polynomial becomes NH expected beats (j, j+N/2).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mk      = 0;
      exp_ovf = 0;
    end else begin
      cyc++;
      if (in_valid) begin
        if (exp_drop) begin
          exp_ovf = 1;
        end else begin
          i0 = brev(2 * mk, LOGN);
          part[i0]      = in_0;
          part[i0 + NH] = in_1;
          if (mk == NH - 1) begin
            for (int j = 0; j < NH; j++) begin
              e.a = part[j];
              e.b = part[j + NH];
              e.l = (j == NH - 1);
              exp_q.push_back(e);
            end
            mk = 0;
            last_in_cyc = cyc;
          end else begin
            mk++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_out_0", 32'(out_0), 32'(prev0));
        chk("hold_out_1", 32'(out_1), 32'(prev1));
        chk("hold_last", 32'(out_last), 32'(prevl));
      end
      if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got %0h/%0h expected no beat", out_0, out_1);
        end else begin
          e = exp_q.pop_front();
          chk("out_0", 32'(out_0), 32'(e.a));
          chk("out_1", 32'(out_1), 32'(e.b));
          chk("out_last", 32'(out_last), 32'(e.l));
        end
        got0.push_back(out_0);
        got1.push_back(out_1);
        n_out++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (out_last) n_last++;
      end
      stall_prev = out_valid && !out_ready;
      prev0 = out_0;
      prev1 = out_1;
      prevl = out_last;
    end else begin
      stall_prev = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Entered and left at posedge+1; consecutive calls give continuous beats.
  task automatic send_poly(input int p, input int mode, input bit drop);
    logic [15:0] c [N];
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       c[i] = 16'(i);
        1:       c[i] = 16'(i + 100 * p);
        default: c[i] = 16'($urandom);
      endcase
    end
    for (int k = 0; k < NH; k++) begin
      if (abort_in) break;
      in_valid = 1'b1;
      in_0     = c[brev(2 * k, LOGN)];
      in_1     = c[brev(2 * k + 1, LOGN)];
      exp_drop = drop;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_drop = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (t >= 2000) begin
      errors++;
      $display("FAIL %s drain timeout got %0d beats left expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_ovf", 32'(overflow), 32'd0);
      chk("idle_out_0", 32'(out_0), 32'd0);
      chk("idle_out_1", 32'(out_1), 32'd0);
    end
    @(posedge clk); #1;

    // Single polynomial with index-valued data
    first_v_cyc = -1;
    n_last = 0;
    got0.delete();
    got1.delete();
    send_poly(0, 0, 0);
    chk("model_size", 32'(exp_q.size()), 32'd8);
    chk("model_first_b", 32'(exp_q[0].b), 32'd8);
    chk("model_last_a", 32'(exp_q[7].a), 32'd7);
    wait_drain("single");
    chk("latency", 32'(first_v_cyc - last_in_cyc), 32'd2);
    chk("single_beats", 32'(got0.size()), 32'd8);
    chk("beat0_out_0", 32'(got0[0]), 32'd0);
    chk("beat0_out_1", 32'(got1[0]), 32'd8);
    chk("beat7_out_0", 32'(got0[7]), 32'd7);
    chk("beat7_out_1", 32'(got1[7]), 32'd15);
    chk("single_lasts", 32'(n_last), 32'd1);

    // Four back-to-back polynomials
    n_out = 0;
    first_pop = -1;
    for (int p = 1; p <= 4; p++) send_poly(p, 1, 0);
    wait_drain("b2b");
    chk("b2b_beats", 32'(n_out), 32'd32);
    chk("b2b_span", 32'(last_pop - first_pop), 32'd31);

    // Random backpressure over two random polynomials
    n_out = 0;
    rand_ready = 1;
    send_poly(5, 2, 0);
    send_poly(6, 2, 0);
    wait_drain("backpressure");
    rand_ready = 0;
    out_ready = 1'b1;
    wait_drain("backpressure_tail");
    chk("bp_beats", 32'(n_out), 32'd16);

    // Overflow: third polynomial dropped while both buffers are full
    n_out = 0;
    out_ready = 1'b0;
    send_poly(7, 1, 0);
    send_poly(8, 1, 0);
    send_poly(9, 1, 1);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("overflow");
    chk("ovf_beats", 32'(n_out), 32'd16);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset while streaming
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_out = 0;
    abort_in = 0;
    fork
      begin
        send_poly(10, 2, 0);
        send_poly(11, 2, 0);
      end
      begin
        int t;
        t = 0;
        while (n_out < 3 && t < 200) begin
          @(posedge clk);
          t++;
        end
        checks++;
        if (t >= 200) begin
          errors++;
          $display("FAIL rst_wait got %0d beats expected 3", n_out);
        end
        #3;
        rst_n = 1'b0;
        abort_in = 1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out_0", 32'(out_0), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
      end
    join
    @(posedge clk);
    #2 rst_n = 1'b1;
    abort_in = 0;
    @(posedge clk); #1;
    n_out = 0;
    send_poly(12, 2, 0);
    wait_drain("after_reset");
    chk("after_reset_beats", 32'(n_out), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
